// File: rtl/seq_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial source stage.
package seq_pkg;

  // Serializer FSM states; the encoding is also what the debug port shows.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  // Width of the completed-frame counter; it wraps from 0xFFFF to 0.
  localparam int FRAME_CNT_W = 16;

  // Bits needed to index 0..n-1; never less than one bit so the counter
  // still exists when n is 1 (for example GAP_CYCLES = 0 gives n = 1).
  function automatic int cnt_w(input int n);
    int w;
    w = (n <= 1) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage : seq_pkg

// File: rtl/seq_serializer_hold_buf.sv
// One-entry holding register that sits behind the active shift register.
// A push captures a word and sets full. A pop clears full. The serializer
// never asks for both in the same cycle: it only accepts a word while the
// buffer is empty, and it only drains the buffer while the buffer is full.
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_out_o
);

  logic             full_q;
  logic             full_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state: a push wins over a pop; a pop only clears the flag.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // Register the flag and the held word; reset discards any held word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o     = full_q;
  assign data_out_o = data_q;

endmodule : ser_hold_buf

// File: rtl/seq_serializer.sv
// Parallel-to-serial source stage that feeds the sequence detector.
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on the holding-buffer
// flag and on reset, never on load_valid. The source keeps the word and
// load_valid stable until that transfer edge. When load_ready is low,
// load_valid is ignored.
//
// Every serial output is a flop loaded from the next-state values. The
// first bit of a word accepted at edge N therefore shows on sequence_out
// during cycle N+1.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic                   sequence_out,
  output logic                   bit_valid,
  output logic                   frame_done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frames_sent,
  output ser_state_t             dbg_state
);

  localparam int BIT_CNT_W = cnt_w(WIDTH);
  localparam int GAP_CNT_W = cnt_w(GAP_CYCLES + 1);
  localparam bit HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP =
    GAP_CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  // FSM and datapath state.
  ser_state_t             state_q;
  ser_state_t             state_d;
  logic [WIDTH-1:0]       shreg_q;
  logic [WIDTH-1:0]       shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q;
  logic [GAP_CNT_W-1:0]   gap_cnt_d;
  logic [FRAME_CNT_W-1:0] frames_q;
  logic [FRAME_CNT_W-1:0] frames_d;

  // Registered serial outputs.
  logic                   seq_q;
  logic                   seq_d;
  logic                   bv_q;
  logic                   bv_d;
  logic                   fd_q;
  logic                   fd_d;

  // Holding-buffer interface.
  logic                   hold_full;
  logic [WIDTH-1:0]       hold_data;
  logic                   hold_push;
  logic                   hold_pop;

  // Edge qualifiers.
  logic                   accept;
  logic                   last_bit;
  logic                   last_gap;
  logic                   shifter_free;
  logic                   word_avail;
  logic [WIDTH-1:0]       next_word;

  assign load_ready = !hold_full && !reset;
  assign accept     = load_valid && load_ready;

  // The shifter is free at this edge when nothing is shifting, when the
  // last bit ends with no gap to follow, or when the last gap cycle ends.
  // A waiting buffered word takes priority over a new word. A new word
  // that finds the shifter busy parks in the holding buffer.
  always_comb begin
    last_bit     = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    last_gap     = HAS_GAP && (state_q == GAP) && (gap_cnt_q == LAST_GAP);
    shifter_free = (state_q == IDLE) || (last_bit && !HAS_GAP) || last_gap;
    word_avail   = hold_full || accept;
    next_word    = hold_full ? hold_data : data_in;
    hold_pop     = shifter_free && hold_full;
    hold_push    = accept && !shifter_free;
  end

  ser_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (hold_push),
    .pop_i      (hold_pop),
    .data_i     (data_in),
    .full_o     (hold_full),
    .data_out_o (hold_data)
  );

  // Next-state for the FSM, shift register and counters. The output flops
  // are loaded from the next state, so each output lines up with the bit
  // that the shifter holds in the same cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    frames_d  = frames_q;

    if (last_bit) begin
      frames_d = frames_q + FRAME_CNT_W'(1);
    end

    if (shifter_free && word_avail) begin
      state_d   = SHIFT;
      shreg_d   = next_word;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (last_bit) begin
            state_d   = HAS_GAP ? GAP : IDLE;
            gap_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end
        GAP: begin
          if (last_gap) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    bv_d  = (state_d == SHIFT);
    seq_d = bv_d ? (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]) : IDLE_LEVEL;
    fd_d  = bv_d && (bit_cnt_d == LAST_BIT);
  end

  // State, datapath and output registers. Reset abandons any frame in
  // flight without counting it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      frames_q  <= '0;
      seq_q     <= IDLE_LEVEL;
      bv_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      frames_q  <= frames_d;
      seq_q     <= seq_d;
      bv_q      <= bv_d;
      fd_q      <= fd_d;
    end
  end

  assign sequence_out = seq_q;
  assign bit_valid    = bv_q;
  assign frame_done   = fd_q;
  assign frames_sent  = frames_q;
  assign busy         = (state_q != IDLE) || hold_full;
  assign dbg_state    = state_q;

endmodule : seq_serializer

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial source stage that feeds the Moore sequence detector's `sequence_in`. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word behind the active shift register. It shifts each word out one bit per clock, optionally inserting idle gap cycles between frames. Its `sequence_out` connects directly to the detector's `sequence_in`, and both blocks share the same clock and reset.

## Interface
- `WIDTH`, 8: bits per word (2..32).
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.
- `GAP_CYCLES`, 0: idle cycles inserted after every frame (0..255).
- `IDLE_LEVEL`, 0: value driven on `sequence_out` when no bit is being sent.

- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `data_in`  in  WIDTH  word to serialize
- `load_valid`  in  1  `data_in` is valid
- `load_ready`  out  1  block can accept a word this cycle
- `sequence_out`  out  1  serial bit stream (to detector `sequence_in`)
- `bit_valid`  out  1  `sequence_out` carries a data bit this cycle
- `frame_done`  out  1  one-cycle pulse coincident with the last bit of a frame
- `busy`  out  1  shifter or holding buffer occupied
- `frames_sent`  out  16  count of completed frames, wraps 0xFFFF→0

## Operation
- Handshake:
  - A transfer occurs on an edge where `load_valid && load_ready`.
  - `load_ready = !hold_full && !reset`. It depends only on registered state, with no path from `load_valid`.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - `sequence_out = IDLE_LEVEL`, `bit_valid = 0`.
  - An accepted word goes straight into the shift register and the FSM moves to SHIFT.
- SHIFT:
  - Drives one bit per cycle, selected per MSB_FIRST.
  - `bit_valid = 1`.
  - The bit counter runs 0..WIDTH-1.
- The shifter is "free at this edge" when any of these holds:
  - state is IDLE;
  - state is SHIFT on the last bit with `GAP_CYCLES == 0`;
  - state is GAP on its last gap cycle.
- Load priority at a free edge:
  - The holding buffer's word goes first.
  - Otherwise an incoming accepted word goes directly into the shifter.
  - An accepted word that finds the shifter not free goes into the holding buffer.
- End of frame:
  - On the last bit, `frame_done = 1` and `frames_sent` increments at that edge.
  - Next state:
    - GAP if `GAP_CYCLES > 0`;
    - otherwise SHIFT if a word is available (no bubble);
    - otherwise IDLE.
- GAP:
  - `sequence_out = IDLE_LEVEL`, `bit_valid = 0`, lasting exactly GAP_CYCLES cycles.
  - Then SHIFT if a word is available, else IDLE.
- `busy = (state != IDLE) || hold_full`.

## Timing
- Reset values (all outputs, from the edge where `reset` is sampled high):
  - state IDLE, holding buffer empty;
  - `sequence_out = IDLE_LEVEL`;
  - `bit_valid = 0`, `frame_done = 0`, `busy = 0`;
  - `frames_sent = 0`;
  - `load_ready = 0` while `reset` is high, `1` the cycle after it drops.
- Latency: a word accepted at edge N with the shifter free has its first bit on `sequence_out` during cycle N+1. All outputs are registered.
- Frame occupancy: exactly WIDTH cycles of `bit_valid` per word. Back-to-back words with `GAP_CYCLES = 0` produce continuous `bit_valid`.
- Sustained throughput: one word per WIDTH+GAP_CYCLES cycles. `load_ready` drops the cycle after the holding buffer fills and rises the cycle after it drains into the shifter.
- Simultaneous events:
  - The buffer draining into the shifter at the same edge as a new accept cannot occur, because `load_ready` is 0 while the buffer is full.
  - An accept at a free edge with the buffer empty bypasses the buffer.
- Reset mid-frame: the frame is abandoned, with no `frame_done` and no count increment. The held word is discarded, and `sequence_out` returns to IDLE_LEVEL on the next cycle.
- `load_valid` while `load_ready = 0`: ignored; the source must hold the word until accepted.

## Structure
- Shared package `seq_pkg`:
  - `typedef enum {IDLE, SHIFT, GAP} ser_state_t`;
  - counter width localparams via `$clog2(WIDTH)` and `$clog2(GAP_CYCLES+1)`;
  - `FRAME_CNT_W = 16`.
- Sub-module `ser_hold_buf`: a one-entry holding register with a `full` flag, `push`/`pop` inputs and a registered `data_out`. The FSM, shift register, counters and output registers stay in the top.

## Test plan
- Single frame:
  - Stimulus: WIDTH=4, MSB_FIRST=1; after reset, accept 4'b1011 at edge N.
  - Required: `sequence_out` = 1,0,1,1 in cycles N+1..N+4, with `bit_valid` high for those cycles.
  - Required: `frame_done` high in cycle N+4, `frames_sent` = 1 afterwards.
  - Required: `sequence_out` = 0 in cycle N+5.
- Back-to-back frames:
  - Stimulus: WIDTH=4, GAP=0, hold `load_valid` high with 4'b1011 then 4'b0110.
  - Required: an 8-cycle continuous stream 1,0,1,1,0,1,1,0, with `load_ready` low while the buffer is full.
- LSB-first with gap:
  - Stimulus: MSB_FIRST=0, GAP_CYCLES=3, two words 4'b0001 and 4'b1000.
  - Required: output 1,0,0,0, then three idle cycles with `bit_valid` low, then 0,0,0,1.
- Backpressure:
  - Stimulus: three words offered continuously.
  - Required: the third is accepted only after the first word's last-bit edge; no word is lost or duplicated; `frames_sent` = 3.
- Reset mid-frame:
  - Stimulus: assert `reset` on the 2nd bit of a frame while the buffer is full.
  - Required: next cycle `sequence_out = IDLE_LEVEL`, `busy = 0`, `frames_sent` unchanged; no `frame_done`.
- Detector integration:
  - Stimulus: chain into the sequence detector and send 8'b0010_1100.
  - Required: `detector_out` asserts exactly at the detector's specified cycle after the matching bits.
